// File: rtl/alu_cmd_issuer.sv
// Front end for a registered 4-bit ALU: queues commands, issues them under a
// response-buffer credit limit, and returns tagged results strictly in issue order.
module alu_cmd_issuer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int RSP_DEPTH   = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_opcode,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic [2:0] alu_opcode,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_result,
   input  logic       alu_carry_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_result,
   output logic       rsp_carry,
   output logic [2:0] rsp_opcode,
   output logic [3:0] rsp_tag,
   output logic       rsp_div0,
   output logic       busy
);
   localparam int STAGES = ALU_LATENCY;
   localparam int CAW    = $clog2(FIFO_DEPTH);
   localparam int RAW    = $clog2(RSP_DEPTH);
   localparam logic [CAW:0] CMD_FULL = (CAW+1)'(FIFO_DEPTH);
   localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   typedef struct packed {
      logic [3:0] tag;
      logic [2:0] op;
      logic       div0;
   } tok_t;

   typedef struct packed {
      tok_t       tok;
      logic [3:0] result;
      logic       carry;
   } rsp_t;

   cmd_t           r_cmd_mem [FIFO_DEPTH];
   logic [CAW-1:0] r_cmd_wp, r_cmd_rp;
   logic [CAW:0]   r_cmd_cnt;

   rsp_t           r_rsp_mem [RSP_DEPTH];
   logic [RAW-1:0] r_rsp_wp, r_rsp_rp;
   logic [RAW:0]   r_rsp_cnt;
   logic [RAW:0]   r_infl_cnt;

   logic [STAGES:0] r_vld_pipe;
   tok_t            r_tok_pipe [STAGES+1];

   logic [3:0] r_tag;
   logic [2:0] r_alu_op;
   logic [3:0] r_alu_a, r_alu_b;

   logic         w_push, w_issue, w_cap, w_pop;
   logic [RAW:0] w_outstanding;
   cmd_t         w_head;
   tok_t         w_tok;
   rsp_t         w_rsp_in, w_rsp_head;

   function automatic logic [RAW-1:0] rsp_inc(input logic [RAW-1:0] p);
      return (p == RAW'(RSP_DEPTH-1)) ? '0 : p + RAW'(1);
   endfunction

   // Credits count everything already committed to the response buffer, so a
   // stalled consumer can never cause a captured result to be lost.
   assign w_outstanding = r_infl_cnt + r_rsp_cnt;
   assign cmd_ready     = !rst && (r_cmd_cnt < CMD_FULL);
   assign w_push        = cmd_valid && cmd_ready;
   assign w_issue       = (r_cmd_cnt != '0) && (w_outstanding < RSP_FULL);
   assign w_cap         = r_vld_pipe[STAGES];
   assign rsp_valid     = (r_rsp_cnt != '0);
   assign w_pop         = rsp_valid && rsp_ready;
   assign w_head        = r_cmd_mem[r_cmd_rp];

   always_comb begin
      w_tok          = '0;
      w_tok.tag      = r_tag;
      w_tok.op       = w_head.op;
      w_tok.div0     = (w_head.op == 3'b011) && (w_head.b == 4'd0);
      w_rsp_in        = '0;
      w_rsp_in.tok    = r_tok_pipe[STAGES];
      w_rsp_in.result = alu_result;
      w_rsp_in.carry  = alu_carry_out;
   end

   // Command queue storage and control
   always_ff @(posedge clk) begin
      if (w_push) r_cmd_mem[r_cmd_wp] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_cnt <= '0;
      end else begin
         if (w_push)  r_cmd_wp <= r_cmd_wp + CAW'(1);
         if (w_issue) r_cmd_rp <= r_cmd_rp + CAW'(1);
         r_cmd_cnt <= r_cmd_cnt + (CAW+1)'(w_push) - (CAW+1)'(w_issue);
      end
   end

   // ALU drive: opcode 111 with zero operands whenever nothing issues
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_op <= 3'b111;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_tag    <= '0;
      end else if (w_issue) begin
         r_alu_op <= w_head.op;
         r_alu_a  <= w_head.a;
         r_alu_b  <= w_head.b;
         r_tag    <= r_tag + 4'd1;
      end else begin
         r_alu_op <= 3'b111;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
      end
   end

   assign alu_opcode = r_alu_op;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;

   // In-flight tracking: clearing the valid pipe on reset drops results still inside the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_infl_cnt <= '0;
      end else begin
         r_vld_pipe <= (r_vld_pipe << 1) | (STAGES+1)'(w_issue);
         r_infl_cnt <= r_infl_cnt + (RAW+1)'(w_issue) - (RAW+1)'(w_cap);
      end
   end

   always_ff @(posedge clk) begin
      r_tok_pipe[0] <= w_tok;
      for (int i = 1; i <= STAGES; i++) r_tok_pipe[i] <= r_tok_pipe[i-1];
   end

   // Response buffer
   always_ff @(posedge clk) begin
      if (w_cap) r_rsp_mem[r_rsp_wp] <= w_rsp_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_wp  <= '0;
         r_rsp_rp  <= '0;
         r_rsp_cnt <= '0;
      end else begin
         if (w_cap) r_rsp_wp <= rsp_inc(r_rsp_wp);
         if (w_pop) r_rsp_rp <= rsp_inc(r_rsp_rp);
         r_rsp_cnt <= r_rsp_cnt + (RAW+1)'(w_cap) - (RAW+1)'(w_pop);
      end
   end

   assign w_rsp_head = rsp_valid ? r_rsp_mem[r_rsp_rp] : '0;
   assign rsp_result = w_rsp_head.result;
   assign rsp_carry  = w_rsp_head.carry;
   assign rsp_opcode = w_rsp_head.tok.op;
   assign rsp_tag    = w_rsp_head.tok.tag;
   assign rsp_div0   = w_rsp_head.tok.div0;

   assign busy = (r_cmd_cnt != '0) || (r_infl_cnt != '0) || (r_rsp_cnt != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: registered ALU stand-in, table vectors, directed
// corner sequences and a randomized phase checked against an in-order expectation queue.
module tb_alu_cmd_issuer;
   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_opcode;
   logic [3:0] cmd_a, cmd_b;
   logic [2:0] alu_opcode;
   logic [3:0] alu_a, alu_b;
   logic [3:0] alu_result = 4'd0;
   logic       alu_carry_out = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic [2:0] rsp_opcode;
   logic [3:0] rsp_tag;
   logic       rsp_div0;
   logic       busy;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.FIFO_DEPTH(4), .RSP_DEPTH(4), .ALU_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_opcode(rsp_opcode),
      .rsp_tag(rsp_tag), .rsp_div0(rsp_div0), .busy(busy)
   );

   function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
      int ia, ib, r, c;
      ia = int'(a); ib = int'(b); r = 0; c = 0;
      case (op)
         3'd0: begin r = (ia + ib) % 16; c = (ia + ib > 15) ? 1 : 0; end
         3'd1: begin r = (ia - ib + 16) % 16; c = (ia < ib) ? 1 : 0; end
         3'd2: r = (ia * ib) % 16;
         3'd3: r = (ib == 0) ? 0 : ia / ib;
         3'd4: r = ia & ib;
         3'd5: r = ia | ib;
         3'd6: r = 15 - ia;
         default: r = 0;
      endcase
      return {c[0], r[3:0]};
   endfunction

   // Registered ALU stand-in: one edge from operand sample to result
   always @(posedge clk) {alu_carry_out, alu_result} <= alu_ref(alu_opcode, alu_a, alu_b);

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Expected response stream: every accepted command, in acceptance order, tagged mod 16
   typedef struct {
      int tag;
      int op;
      int res;
      int carry;
      int div0;
   } exp_t;
   exp_t       exp_q[$];
   int         m_tag = 0;
   int         got_tag[$];
   int         got_cyc[$];
   exp_t       mon_e;
   logic [4:0] mon_cr;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_tag = 0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("mon_tag",    rsp_tag,    mon_e.tag);
               chk("mon_opcode", rsp_opcode, mon_e.op);
               chk("mon_result", rsp_result, mon_e.res);
               chk("mon_carry",  rsp_carry,  mon_e.carry);
               chk("mon_div0",   rsp_div0,   mon_e.div0);
            end
            got_tag.push_back(int'(rsp_tag));
            got_cyc.push_back(cyc);
         end
         if (cmd_valid && cmd_ready) begin
            mon_cr = alu_ref(cmd_opcode, cmd_a, cmd_b);
            exp_q.push_back('{m_tag, int'(cmd_opcode), int'(mon_cr[3:0]), int'(mon_cr[4]),
                              (cmd_opcode == 3'd3 && cmd_b == 4'd0) ? 1 : 0});
            m_tag = (m_tag + 1) % 16;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic rand_cmd(input int max_op);
      cmd_opcode = 3'($urandom_range(0, max_op));
      cmd_a      = 4'($urandom_range(0, 15));
      cmd_b      = 4'($urandom_range(0, 15));
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      bit ok = 1'b0;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic drain(input string nm);
      bit done = 1'b0;
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      chk({nm, "_drain"}, 32'(done), 1);
      chk({nm, "_leftover"}, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] a, b, res;
      logic       carry, div0;
   } vec_t;
   localparam int NV = 10;
   vec_t vecs [NV];

   int acc, iss, base;
   bit hs, found;

   initial begin
      vecs[0] = '{3'd0, 4'd9,  4'd8,  4'd1,  1'b1, 1'b0};
      vecs[1] = '{3'd1, 4'd3,  4'd5,  4'd14, 1'b1, 1'b0};
      vecs[2] = '{3'd3, 4'd7,  4'd0,  4'd0,  1'b0, 1'b1};
      vecs[3] = '{3'd3, 4'd13, 4'd4,  4'd3,  1'b0, 1'b0};
      vecs[4] = '{3'd2, 4'd5,  4'd3,  4'd15, 1'b0, 1'b0};
      vecs[5] = '{3'd4, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0};
      vecs[6] = '{3'd5, 4'd12, 4'd3,  4'd15, 1'b0, 1'b0};
      vecs[7] = '{3'd6, 4'd5,  4'd0,  4'd10, 1'b0, 1'b0};
      vecs[8] = '{3'd0, 4'd7,  4'd8,  4'd15, 1'b0, 1'b0};
      vecs[9] = '{3'd1, 4'd5,  4'd5,  4'd0,  1'b0, 1'b0};

      cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready",  cmd_ready,  0);
      chk("rst_rsp_valid",  rsp_valid,  0);
      chk("rst_busy",       busy,       0);
      chk("rst_alu_opcode", alu_opcode, 7);
      chk("rst_alu_a",      alu_a,      0);
      chk("rst_alu_b",      alu_b,      0);
      chk("rst_rsp_fields", {rsp_result, rsp_carry, rsp_opcode, rsp_tag, rsp_div0}, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;

      // Single ops: latency, ALU drive, result fields, tag sequence
      rsp_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b);
         @(negedge clk);
         chk("t1_lat_e0", rsp_valid, 0);
         @(negedge clk);
         chk("t1_lat_e1", rsp_valid, 0);
         chk("t1_alu_op", alu_opcode, vecs[i].op);
         chk("t1_alu_ab", {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
         @(negedge clk);
         chk("t1_lat_e2", rsp_valid, 0);
         chk("t1_alu_nop", alu_opcode, 7);
         @(negedge clk);
         chk("t1_lat_e3", rsp_valid, 1);
         chk("t1_result", rsp_result, vecs[i].res);
         chk("t1_carry",  rsp_carry,  vecs[i].carry);
         chk("t1_div0",   rsp_div0,   vecs[i].div0);
         chk("t1_opcode", rsp_opcode, vecs[i].op);
         chk("t1_tag",    rsp_tag,    i);
         @(posedge clk); #1;
      end
      drain("t1");

      // Back-to-back: full throughput, no backpressure on commands
      do_reset();
      rsp_ready = 1'b1;
      got_tag.delete(); got_cyc.delete();
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rand_cmd(6);
         @(negedge clk);
         chk("t3_cmd_ready", cmd_ready, 1);
         @(posedge clk); #1;
      end
      drain("t3");
      chk("t3_rsp_count", got_tag.size(), 6);
      for (int i = 0; i < got_tag.size() && i < 6; i++) chk("t3_tag_order", got_tag[i], i);
      for (int i = 1; i < got_cyc.size() && i < 6; i++)
         chk("t3_one_per_cycle", got_cyc[i] - got_cyc[i-1], 1);

      // Stalled consumer: credit limit caps issue at RSP_DEPTH
      rsp_ready = 1'b0; acc = 0; iss = 0;
      got_tag.delete();
      rand_cmd(6); cmd_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (alu_opcode != 3'b111) iss++;
         hs = cmd_valid && cmd_ready;
         if (hs) acc++;
         @(posedge clk); #1;
         if (acc == 8) cmd_valid = 1'b0;
         else if (hs) rand_cmd(6);
      end
      chk("t4_issues",     iss, 4);
      chk("t4_accepts",    acc, 8);
      chk("t4_cmd_ready",  cmd_ready, 0);
      chk("t4_busy",       busy, 1);
      chk("t4_alu_nop",    alu_opcode, 7);
      chk("t4_none_early", got_tag.size(), 0);
      drain("t4");
      chk("t4_rsp_count", got_tag.size(), 8);

      // Tag wrap
      do_reset();
      rsp_ready = 1'b1;
      got_tag.delete();
      for (int i = 0; i < 17; i++) send(3'd0, 4'(i), 4'd1);
      drain("t5");
      chk("t5_rsp_count", got_tag.size(), 17);
      for (int i = 0; i < got_tag.size() && i < 17; i++) chk("t5_tag_wrap", got_tag[i], i % 16);

      // Reset with work queued and in flight
      do_reset();
      rsp_ready = 1'b0; acc = 0;
      rand_cmd(6); cmd_valid = 1'b1;
      for (int c = 0; c < 20 && acc < 4; c++) begin
         @(negedge clk);
         hs = cmd_valid && cmd_ready;
         if (hs) acc++;
         @(posedge clk); #1;
         if (hs) rand_cmd(6);
      end
      chk("t6_accepts", acc, 4);
      rst = 1'b1; cmd_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_busy",      busy, 0);
      chk("t6_alu_nop",   alu_opcode, 7);
      chk("t6_cmd_ready", cmd_ready, 1);
      rsp_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t6_no_stale", rsp_valid, 0);
      end
      @(posedge clk); #1;
      send(3'd0, 4'd2, 4'd3);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (rsp_valid) found = 1'b1;
      end
      chk("t6_rsp_seen", 32'(found), 1);
      chk("t6_tag0",     rsp_tag, 0);
      chk("t6_result",   rsp_result, 5);
      @(posedge clk); #1;
      drain("t6");

      // Randomized traffic with random backpressure
      got_tag.delete();
      base = 0;
      for (int c = 0; c < 400; c++) begin
         cmd_valid = ($urandom_range(0, 9) < 7);
         rand_cmd(7);
         rsp_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
         if (cmd_valid && cmd_ready) base++;
         @(posedge clk); #1;
      end
      drain("rnd");
      chk("rnd_rsp_count", got_tag.size(), base);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator-side front end for the 4-bit clocked ALU. It accepts operation commands over a valid/ready interface and queues them. It drives opcode/A/B into the ALU, captures the registered result and carry, and returns them in issue order with a sequence tag over a valid/ready response interface. Credit-based issue guarantees no ALU result is ever dropped under response backpressure.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
RSP_DEPTH, 4, response buffer entries; also the maximum number of outstanding ops (in-flight + buffered)
ALU_LATENCY, 1, clock edges from ALU input sample to valid ALU result (the ALU is registered, so 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command queue can accept
cmd_opcode  in  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 not, 111 nop)
cmd_a  in  4  operand A
cmd_b  in  4  operand B
alu_opcode  out  3  opcode to ALU
alu_a  out  4  operand A to ALU
alu_b  out  4  operand B to ALU
alu_result  in  4  ALU result
alu_carry_out  in  1  ALU carry
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  4  captured result
rsp_carry  out  1  captured carry
rsp_opcode  out  3  opcode of this response
rsp_tag  out  4  issue sequence number
rsp_div0  out  1  op was 011 with B==0
busy  out  1  any command queued, in flight, or buffered

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Command FIFO, in-flight pipeline, and response FIFO are emptied. Tag counter is set to 0.
  - alu_opcode=3'b111, alu_a=0, alu_b=0.
  - rsp_valid=0, and rsp_result, rsp_carry, rsp_opcode, rsp_tag, rsp_div0 are all 0.
  - cmd_ready=0 while rst=1, and busy=0.
  - If reset is asserted mid-operation, results still emerging from the ALU in later cycles are discarded. No stale response ever appears.
- Command side:
  - cmd_ready = !rst && (cmd_count < FIFO_DEPTH), computed from registered count only.
  - A push occurs on cmd_valid && cmd_ready.
  - When the FIFO is full, a same-cycle pop does not allow a push; cmd_ready stays 0 that cycle.
  - Push to an empty FIFO and pop are not bypassed: an entry is poppable the edge after it is written.
- Issue:
  - Condition: the command FIFO is non-empty and (inflight_count + rsp_count) < RSP_DEPTH. Counts are registered; a same-cycle response pop is not credited.
  - On issue, the head is popped and alu_opcode/alu_a/alu_b are registered from it. A token {tag, opcode, div0} enters the in-flight shift pipeline, which is ALU_LATENCY+1 stages long. The tag counter increments and wraps 15->0.
  - On non-issue cycles, alu_opcode=3'b111 and alu_a=alu_b=0 (ALU nop).
  - At most one issue per cycle.
- Capture:
  - When the last pipeline stage holds a valid token, alu_result and alu_carry_out are written into the response FIFO together with the token.
  - Carry is passed through as delivered; the ALU drives it as 0 for non-add/sub ops.
  - The response FIFO cannot overflow because of the credit rule.
- Latency: with an empty pipeline, a command accepted at edge k issues at k+1, is sampled by the ALU at k+2, is captured at k+3, and rsp_valid=1 after edge k+3.
- Throughput: 1 op/cycle sustained when rsp_ready=1.
- Response side:
  - rsp_* are driven from the response FIFO head. A pop occurs on rsp_valid && rsp_ready.
  - Responses are returned strictly in issue order.
- div0 is computed at issue as (opcode==3'b011 && b==0). rsp_result for that case is whatever the ALU returns, which is 0.
- Simultaneous events: command push, issue, capture, and response pop may all occur in one cycle. Each count updates by (in − out) correctly in that cycle.
- busy = (cmd_count != 0) || (inflight_count != 0) || (rsp_count != 0).

Test Plan:
1. Add op=000, A=9, B=8, rsp_ready=1 -> rsp_result=1, rsp_carry=1, tag=0, rsp_valid rises 3 edges after accept. Sub op=001, A=3, B=5 -> result=14, carry=1, tag=1.
2. Div op=011, A=7, B=0 -> rsp_result=0, rsp_div0=1. Div A=13, B=4 -> result=3, div0=0. Mul A=5, B=3 -> result=15, carry=0.
3. 6 back-to-back commands with cmd_valid=1 and rsp_ready=1 -> after the first response, one response per cycle, tags 0..5 in order, cmd_ready never drops.
4. rsp_ready=0 with 8 commands offered -> exactly 4 issues, then alu_opcode stays 111; cmd_ready falls after 4 are queued; busy=1. Raise rsp_ready -> all 8 responses arrive, in order, correct, none lost or duplicated.
5. 17 sequential commands -> rsp_tag runs 0..15 then 0.
6. Assert rst for 1 cycle with 2 ops in flight and 2 queued -> next cycle rsp_valid=0, busy=0, alu_opcode=111, cmd_ready=1 after rst drops. No response appears in the following 5 cycles. A new command then returns tag=0.
